// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding downstream memory port
// between instruction fetch (requester 0) and data memory (requester 1).
// The arbiter grants one transaction at a time and breaks ties round-robin.
// It holds the grant until the downstream completes or the watchdog fires,
// then pulses ready (and error on timeout) to the owner for one cycle.

// Per-requester lane: decodes the request and gates the completion pulse.
module mem_port_arb_lane #(
  parameter int DATA_W = 32
) (
  input  logic              i_read,
  input  logic              i_write,
  input  logic              i_resp,
  input  logic              i_own,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_req,
  output logic              o_wr,
  output logic              o_ready,
  output logic              o_error,
  output logic [DATA_W-1:0] o_rdata
);

  // A request with both read and write high is treated as a write.
  assign o_req   = i_read | i_write;
  assign o_wr    = i_write;
  assign o_ready = i_resp & i_own;
  assign o_error = o_ready & i_err;
  assign o_rdata = i_rdata;

endmodule

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_ready,
  output logic              r0_error,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_ready,
  output logic              r1_error,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic [1:0]        owner,
  output logic              busy
);

  localparam int NUM_REQ = 2;
  // The counter must hold the value TIMEOUT itself, so it never wraps before the compare.
  localparam int CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] TO_V = (CNT_W + 1)'(TIMEOUT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_rd;
  logic [NUM_REQ-1:0] w_wr_in;
  logic [NUM_REQ-1:0] w_req_v;
  logic [NUM_REQ-1:0] w_req_wr;
  logic [NUM_REQ-1:0] w_ready;
  logic [NUM_REQ-1:0] w_error;
  logic [NUM_REQ-1:0][DATA_W-1:0] w_rdata;

  logic [1:0]        r_state;
  logic              r_m_read;
  logic              r_m_write;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic [1:0]        r_owner;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_win;
  logic              w_resp;
  logic [CNT_W:0]    w_cnt_inc;
  logic              w_timeout;

  assign w_req[0] = {r0_addr, r0_wdata};
  assign w_req[1] = {r1_addr, r1_wdata};
  assign w_rd     = {r1_read, r0_read};
  assign w_wr_in  = {r1_write, r0_write};
  assign w_resp   = (r_state == ST_RESP);

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      mem_port_arb_lane #(.DATA_W(DATA_W)) u_lane (
        .i_read  (w_rd[g]),
        .i_write (w_wr_in[g]),
        .i_resp  (w_resp),
        .i_own   (r_owner[g]),
        .i_err   (r_err),
        .i_rdata (r_rdata),
        .o_req   (w_req_v[g]),
        .o_wr    (w_req_wr[g]),
        .o_ready (w_ready[g]),
        .o_error (w_error[g]),
        .o_rdata (w_rdata[g])
      );
    end
  endgenerate

  // Winner select: a lone requester wins; on a tie, the one not granted last time wins.
  always_comb begin
    w_win = 1'b0;
    if (&w_req_v) w_win = ~r_last;
    else          w_win = w_req_v[1];
  end

  // Watchdog: the timeout fires once the BUSY cycle count reaches TIMEOUT.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == TO_V);

  // Main control: grant, hold the downstream request, complete or time out, respond.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_m_read  <= 1'b0;
      r_m_write <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_owner   <= 2'b00;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req_v) begin
            r_m_addr  <= w_req[w_win].addr;
            r_m_wdata <= w_req[w_win].wdata;
            r_m_write <= w_req_wr[w_win];
            r_m_read  <= ~w_req_wr[w_win];
            r_owner   <= w_win ? 2'b10 : 2'b01;
            r_last    <= w_win;
            r_cnt     <= '0;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (m_ready) begin
            r_rdata   <= m_rdata;
            r_err     <= 1'b0;
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
            r_state   <= ST_RESP;
          end else if (w_timeout) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
          end
        end
        ST_RESP: begin
          r_owner <= 2'b00;
          r_err   <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_read   = r_m_read;
  assign m_write  = r_m_write;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign owner    = r_owner;
  assign busy     = (r_state != ST_IDLE);
  assign r0_ready = w_ready[0];
  assign r1_ready = w_ready[1];
  assign r0_error = w_error[0];
  assign r1_error = w_error[1];
  assign r0_rdata = w_rdata[0];
  assign r1_rdata = w_rdata[1];

endmodule
